// File: rtl/rng_gen_n.sv
`default_nettype none
// ============================================================================
//  Module   : rng_gen_n
//  Purpose  : Random word generator built from LANES independent 16-bit
//             Fibonacci LFSR lanes (taps 16,14,13,11). Each lane contributes
//             its low byte to every captured word. Words leave through a
//             single-entry valid/ready register with backpressure. Also
//             supports run-time reseeding and a saturating count of
//             delivered words.
//  Revision : 1.0  initial release
// ============================================================================
module rng_gen_n #(
    parameter int LANES        = 4,   // 1..16
    parameter int SAMPLE_STEPS = 8    // 8..255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [8*LANES-1:0] output_signal,
    output logic [15:0]        word_cnt
);

    localparam int          OUT_W        = 8 * LANES;
    localparam logic [15:0] c_reset_seed = 16'hACE1;
    localparam logic [7:0]  c_last_step  = 8'(SAMPLE_STEPS - 1);
    localparam logic [15:0] c_cnt_max    = 16'hFFFF;

    logic             r_valid;
    logic [OUT_W-1:0] r_word;
    logic [15:0]      r_word_cnt;
    logic [7:0]       r_step_cnt;

    logic             w_step;
    logic             w_accept;
    logic             w_capture;
    logic [OUT_W-1:0] w_capture_word;

    // Lanes advance only when the output register can take a new word,
    // so a stalled consumer freezes the whole generator.
    assign w_step    = enable & (~r_valid | out_ready);
    assign w_accept  = r_valid & out_ready;
    assign w_capture = w_step & (r_step_cnt == c_last_step);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        // Per-lane salt keeps lanes decorrelated when seeded with one value.
        localparam logic [15:0] c_lane_salt = 16'(gi) << 4;

        logic [15:0] r_state;
        logic [15:0] w_stepped;
        logic [15:0] w_seeded;
        logic [15:0] w_seed_safe;

        assign w_stepped   = {r_state[14:0],
                              r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
        assign w_seeded    = seed ^ c_lane_salt;
        // An all-zero LFSR would lock up, so substitute the reset pattern.
        assign w_seed_safe = (w_seeded == 16'h0000) ? c_reset_seed : w_seeded;

        // The captured byte is the lane state after the capturing step.
        assign w_capture_word[8*gi +: 8] = w_stepped[7:0];

        // Lane state register: reset, reseed, or one LFSR step.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_reset_seed ^ c_lane_salt;
            end else if (seed_load) begin
                r_state <= w_seed_safe;
            end else if (w_step) begin
                r_state <= w_stepped;
            end
        end
    end

    // Step counter: counts steps within a word, wraps on capture.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            r_step_cnt <= 8'd0;
        end else if (w_step) begin
            r_step_cnt <= w_capture ? 8'd0 : (r_step_cnt + 8'd1);
        end
    end

    // Output register: a capture overrides an accept in the same cycle, so
    // back-to-back words flow without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (seed_load) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_word  <= w_capture_word;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Delivered-word counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            r_word_cnt <= 16'd0;
        end else if (w_accept && (r_word_cnt != c_cnt_max)) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign out_valid     = r_valid;
    assign output_signal = r_word;
    assign word_cnt      = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rng_gen_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rng_gen_n
//  Purpose  : Self-checking bench for rng_gen_n. Two instances (8 and 11
//             steps per word) share stimulus; a behavioural model tracks
//             each and is compared every cycle, with literal pins on the
//             known first words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rng_gen_n;

    localparam int LANES = 4;
    localparam int SS_A  = 8;
    localparam int SS_B  = 11;
    localparam int OUT_W = 8 * LANES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             seed_load = 1'b0;
    logic [15:0]      seed = 16'h0000;
    logic             out_ready = 1'b0;

    logic             valid_a, valid_b;
    logic [OUT_W-1:0] word_a, word_b;
    logic [15:0]      cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rng_gen_n #(.LANES(LANES), .SAMPLE_STEPS(SS_A)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .seed(seed), .out_ready(out_ready), .out_valid(valid_a),
        .output_signal(word_a), .word_cnt(cnt_a)
    );

    rng_gen_n #(.LANES(LANES), .SAMPLE_STEPS(SS_B)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .seed(seed), .out_ready(out_ready), .out_valid(valid_b),
        .output_signal(word_b), .word_cnt(cnt_b)
    );

    // ---------------- behavioural model ----------------
    logic [15:0]      m_lane  [2][LANES];
    int               m_phase [2];
    bit               m_valid [2];
    logic [OUT_W-1:0] m_word  [2];
    int               m_wcnt  [2];
    int               m_accepts_b = 0;
    bit               check_on = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_edge(input int k, input int ss);
        bit          acc, stp;
        logic [15:0] v;
        if (rst) begin
            for (int i = 0; i < LANES; i++) m_lane[k][i] = 16'hACE1 ^ 16'(i * 16);
            m_phase[k] = 0; m_valid[k] = 1'b0; m_word[k] = '0; m_wcnt[k] = 0;
        end else if (seed_load) begin
            for (int i = 0; i < LANES; i++) begin
                v = seed ^ 16'(i * 16);
                m_lane[k][i] = (v == 16'h0000) ? 16'hACE1 : v;
            end
            m_phase[k] = 0; m_valid[k] = 1'b0; m_wcnt[k] = 0;
        end else begin
            acc = m_valid[k] && out_ready;
            stp = enable && (!m_valid[k] || out_ready);
            if (acc) begin
                m_valid[k] = 1'b0;
                if (m_wcnt[k] < 65535) m_wcnt[k] = m_wcnt[k] + 1;
                if (k == 1) m_accepts_b = m_accepts_b + 1;
            end
            if (stp) begin
                for (int i = 0; i < LANES; i++) m_lane[k][i] = lfsr_next(m_lane[k][i]);
                m_phase[k] = (m_phase[k] + 1) % ss;
                if (m_phase[k] == 0) begin
                    for (int i = 0; i < LANES; i++) m_word[k][8*i +: 8] = m_lane[k][i][7:0];
                    m_valid[k] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, SS_A);
        model_edge(1, SS_B);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_on) begin
            check("a_valid", 64'(valid_a), 64'(m_valid[0]));
            check("a_word",  64'(word_a),  64'(m_word[0]));
            check("a_cnt",   64'(cnt_a),   64'(m_wcnt[0]));
            check("b_valid", 64'(valid_b), 64'(m_valid[1]));
            check("b_word",  64'(word_b),  64'(m_word[1]));
            check("b_cnt",   64'(cnt_b),   64'(m_wcnt[1]));
        end
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(valid_a), 64'd1);
    endtask

    task automatic pulse_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // Expect out_valid low for 7 more edges and high on the 8th.
    task automatic expect_latency(input string name);
        repeat (SS_A - 1) @(negedge clk);
        check({name, "_early"}, 64'(valid_a), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(valid_a), 64'd1);
    endtask

    logic [OUT_W-1:0] hold_word;
    int               cyc;

    initial begin
        // ---- reset ----
        repeat (2) @(negedge clk);
        check_on = 1'b1;
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_word",  64'(word_a),  64'd0);
        check("rst_cnt",   64'(cnt_a),   64'd0);

        // ---- first word from reset: lane 0 reaches 16'hE1E4 ----
        rst = 1'b0; enable = 1'b1; out_ready = 1'b1;
        expect_latency("first");
        check("first_byte0", 64'(word_a[7:0]), 64'h0E4);
        @(negedge clk);
        check("first_cnt", 64'(cnt_a), 64'd1);

        // ---- reseed zero guard on lane 1 ----
        pulse_seed(16'h0010);
        check("seed_valid_clr", 64'(valid_a), 64'd0);
        check("seed_cnt_clr",   64'(cnt_a),   64'd0);
        expect_latency("seed10");
        check("seed10_byte1", 64'(word_a[15:8]), 64'h0E4);

        // ---- reseed zero guard on lane 0 ----
        pulse_seed(16'h0000);
        expect_latency("seed00");
        check("seed00_byte0", 64'(word_a[7:0]), 64'h0E4);

        // ---- backpressure: 20 stalled cycles ----
        wait_valid("stall_wait");
        out_ready = 1'b0;
        hold_word = word_a;
        repeat (20) begin
            @(negedge clk);
            check("stall_word",  64'(word_a),  64'(hold_word));
            check("stall_valid", 64'(valid_a), 64'd1);
        end
        out_ready = 1'b1;
        expect_latency("after_stall");

        // ---- enable toggling: 8 enabled edges span 15 clocks ----
        pulse_seed(16'h1234);
        for (int i = 0; i < 14; i++) begin
            enable = (i % 2 == 0);
            @(negedge clk);
        end
        check("toggle_early", 64'(valid_a), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        check("toggle_valid", 64'(valid_a), 64'd1);
        for (int i = 0; i < 100; i++) begin
            enable = (i % 2 == 0);
            @(negedge clk);
        end
        enable = 1'b1;

        // ---- reseed with a word pending, reset mid-word ----
        wait_valid("pend_wait");
        out_ready = 1'b0;
        pulse_seed(16'hBEEF);
        check("pend_seed_valid", 64'(valid_a), 64'd0);
        check("pend_seed_cnt",   64'(cnt_a),   64'd0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(valid_a), 64'd0);
        check("mid_rst_cnt",   64'(cnt_a),   64'd0);
        rst = 1'b0;
        expect_latency("restart");

        // ---- word counter saturation ----
        out_ready = 1'b0;
        @(negedge clk);
        check_on = 1'b0;
        force dut_a.r_word_cnt = 16'hFFFE;
        m_wcnt[0] = 16'hFFFE;
        @(negedge clk);
        release dut_a.r_word_cnt;
        @(negedge clk);
        check_on = 1'b1;
        check("sat_preset", 64'(cnt_a), 64'h0FFFE);
        out_ready = 1'b1;
        repeat (5 * SS_A) @(negedge clk);
        check("sat_cnt", 64'(cnt_a), 64'h0FFFF);

        // ---- randomized run: at least 1000 words from the 11-step instance ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_accepts_b = 0;
        cyc = 0;
        while (m_accepts_b < 1000 && cyc < 60000) begin
            enable    = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            seed_load = ($urandom_range(0, 599) == 0);
            seed      = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15) << 4)
                                                    : 16'($urandom);
            rst       = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0; seed_load = 1'b0;
        check("rand_words_done", 64'(m_accepts_b >= 1000), 64'd1);
        @(negedge clk);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rng_gen_n.md
# rng_gen_n

Parametrised random word generator built from LANES independent 16-bit LFSR lanes. Each lane contributes one fresh byte per word. Words are delivered through a single-entry valid/ready output register with backpressure. The block adds run-time reseeding, a configurable number of steps per sample, and a delivered-word counter, and is the general-width generator for the root-of-trust datapath.

## Interface
- LANES, 4, number of 8-bit lanes; legal 1..16; output width OUT_W = 8*LANES
- SAMPLE_STEPS, 8, LFSR steps per captured word; legal 8..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  generation enable; when low, lanes and step counter hold
- seed_load  input  1  one-cycle reseed strobe
- seed  input  16  seed value, sampled when seed_load=1
- out_ready  input  1  consumer accepts word
- out_valid  output  1  output_signal holds an unconsumed word
- output_signal  output  OUT_W  random word; lane i drives bits [8i+7:8i]
- word_cnt  output  16  words accepted since reset/reseed, saturating

## Operation
- Lane i state is 16 bits, Fibonacci LFSR with taps 16,14,13,11.
  - One step: fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0], fb}.
- Reset: lane i = 16'hACE1 ^ (i<<4); step counter = 0; out_valid = 0; output_signal = 0; word_cnt = 0.
- Reseed, when seed_load=1 and rst=0:
  - lane i = seed ^ (i<<4); if that result is 16'h0000, lane i = 16'hACE1 instead.
  - Step counter cleared, out_valid cleared, word_cnt cleared, output_signal unchanged.
  - No step occurs in that cycle.
- Priority: rst > seed_load > normal operation.
- Step condition: step = enable & (!out_valid | out_ready). All lanes step together.
- Step counter runs 0..SAMPLE_STEPS-1 and wraps. It advances only on step.
- Capture happens on a step with counter == SAMPLE_STEPS-1:
  - output_signal <= concatenation of each lane's post-step s[7:0]; out_valid <= 1.
- Handshake: a word is accepted when out_valid & out_ready.
  - On accept without capture: out_valid <= 0; output_signal holds its last value.
  - On accept with capture in the same cycle: the new word replaces the old one and out_valid stays 1 (no bubble).
- Stall: while out_valid=1 and out_ready=0, lanes and counter freeze, and output_signal and out_valid are stable.
- enable=0 freezes lanes and counter only. A pending word remains available and can be accepted.
- word_cnt increments on each accept and saturates at 16'hFFFF.

## Timing
- Single clock domain. All outputs are registered; no combinational input-to-output paths.
- Capture latency: with enable=1 and out_ready=1 from the first edge after rst falls, out_valid rises after the SAMPLE_STEPS-th edge. After that, one word is produced every SAMPLE_STEPS cycles.
- Throughput with continuous ready is 1 word per SAMPLE_STEPS cycles. Backpressure adds exactly the stalled cycles.
- seed_load takes effect at the same edge. The first post-seed word arrives SAMPLE_STEPS stepping edges later.
- rst or seed_load mid-word discards the partial step count and any pending word.

## Test plan
- LANES=1, SAMPLE_STEPS=8, rst then enable=1, out_ready=1 -> out_valid rises after the 8th edge; output_signal=8'hE4 (lane 0 state 16'hE1E4); word_cnt=1 one edge later.
- LANES=2, seed_load with seed=16'h0010 -> lane 1 zero-guarded to 16'hACE1, so the first word has [15:8]=8'hE4; seed=16'h0000 -> [7:0]=8'hE4.
- Hold out_ready=0 for 20 cycles after first capture -> output_signal and out_valid stable, no lane steps; release -> next word arrives 8 cycles after accept, matching a reference model.
- Toggle enable 1/0 every cycle with out_ready=1 -> capture after 8 enabled edges (15 clocks); sequence identical to the continuous-enable run.
- Assert seed_load while out_valid=1 and rst while counter=5 -> out_valid=0 and word_cnt=0 next edge; restart latency is 8 steps.
- Force word_cnt to 16'hFFFE (or run 65,537 accepts) -> saturates at 16'hFFFF; model check of 1000 words with LANES=4, SAMPLE_STEPS=11.
